imem_loader: RTL

Hardware program loader and run monitor for the single-cycle xgriscv core: it accepts a byte stream carrying a program image and writes it word-by-word into instruction memory. It holds the core in reset while loading, releases it when the image is complete, then watches the writeback PC for the halt address and counts run cycles. It replaces the simulation-only backdoor memory preload and end-of-program check with synthesizable logic usable on the board.

---
 rtl/xgriscv_pkg.sv | 17 +
 rtl/loader_word_asm.sv | 52 +++++
 rtl/imem_loader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/xgriscv_pkg.sv
// Shared loader types and constants for the xgriscv board flow.
// Holds the program-loader state encoding and image framing sizes.
package xgriscv_pkg;

  typedef enum logic [2:0] {
    LD_HDR0,
    LD_HDR1,
    LD_DATA,
    LD_CSUM,
    LD_RUN,
    LD_ERR
  } ld_state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/loader_word_asm.sv
// Byte-to-word assembler for the imem loader.
// Packs little-endian bytes and emits one registered imem write per word.
module loader_word_asm
  import xgriscv_pkg::*;
#(
  parameter int IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               byte_en,
  input  logic [7:0]         byte_in,
  output logic               word_done,
  output logic [IMEM_AW:0]   word_cnt,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata
);

  logic [1:0]  bcnt;
  logic [23:0] shreg;

  assign word_done = byte_en && (bcnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcnt       <= '0;
      shreg      <= '0;
      word_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= word_done;
      if (word_done) begin
        imem_addr  <= word_cnt[IMEM_AW-1:0];
        imem_wdata <= {byte_in, shreg};
      end
      if (clr) begin
        bcnt     <= '0;
        word_cnt <= '0;
      end else if (byte_en) begin
        bcnt  <= bcnt + 2'd1;
        // oldest byte drifts down toward [7:0]
        shreg <= {byte_in, shreg[23:8]};
        if (word_done)
          word_cnt <= word_cnt + (IMEM_AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader and run monitor: streams an image into imem, runs the core.
// Define IMEM_LOADER_CHKSUM_EN to require a trailing payload checksum byte.
module imem_loader
  import xgriscv_pkg::*;
#(
  parameter int          IMEM_AW = 8,
  parameter logic [31:0] HALT_PC = 32'h0000_00fc
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               s_valid,
  input  logic [7:0]         s_data,
  output logic               s_ready,
  input  logic               start,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_rstn,
  input  logic [31:0]        pc_w,
  output logic               halted,
  output logic               err,
  output logic [31:0]        cycles
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << IMEM_AW;

  ld_state_e state_q, state_d;

  logic [7:0]       cnt_lo;
  logic [IMEM_AW:0] nwords;
  logic [15:0]      hdr_n;
  logic             hdr_bad;
  logic             xfer;
  logic             start_ok;
  logic             loading;
  logic             word_done;
  logic             last_word;
  logic [IMEM_AW:0] word_cnt;

  assign loading = (state_q == LD_HDR0) || (state_q == LD_HDR1)
                || (state_q == LD_DATA) || (state_q == LD_CSUM);
  // held low while in reset so every output reads 0
  assign s_ready  = rstn && loading;
  assign xfer     = s_valid && s_ready;
  assign start_ok = start
                 && ((state_q == LD_RUN) || (state_q == LD_ERR));

  assign hdr_n   = {s_data, cnt_lo};
  assign hdr_bad = (hdr_n == 16'd0) || ({1'b0, hdr_n} > MAX_WORDS);
  assign last_word = word_done
                  && (word_cnt == nwords - (IMEM_AW+1)'(1));

`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      sum_q <= '0;
    else if (state_q == LD_HDR1)
      sum_q <= '0;
    else if (xfer && state_q == LD_DATA)
      sum_q <= sum_q + s_data;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LD_HDR0:
        if (xfer) state_d = LD_HDR1;
      LD_HDR1:
        if (xfer) state_d = hdr_bad ? LD_ERR : LD_DATA;
      LD_DATA:
        if (last_word) begin
`ifdef IMEM_LOADER_CHKSUM_EN
          state_d = LD_CSUM;
`else
          state_d = LD_RUN;
`endif
        end
`ifdef IMEM_LOADER_CHKSUM_EN
      LD_CSUM:
        if (xfer) state_d = (s_data == sum_q) ? LD_RUN : LD_ERR;
`endif
      LD_RUN, LD_ERR:
        if (start) state_d = LD_HDR0;
      default:
        state_d = LD_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= LD_HDR0;
      cnt_lo    <= '0;
      nwords    <= '0;
      core_rstn <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      core_rstn <= (state_q == LD_RUN);
      err       <= (state_d == LD_ERR);
      if (xfer && state_q == LD_HDR0)
        cnt_lo <= s_data;
      if (xfer && state_q == LD_HDR1)
        nwords <= hdr_n[IMEM_AW:0];
    end
  end

  // start outranks a same-edge halt
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halted <= 1'b0;
      cycles <= '0;
    end else if (start_ok) begin
      halted <= 1'b0;
      cycles <= '0;
    end else if (state_q == LD_RUN && core_rstn) begin
      if (pc_w == HALT_PC)
        halted <= 1'b1;
      if (!halted && cycles != '1)
        cycles <= cycles + 32'd1;
    end
  end

  loader_word_asm #(
    .IMEM_AW (IMEM_AW)
  ) u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (state_q != LD_DATA),
    .byte_en    (xfer && state_q == LD_DATA),
    .byte_in    (s_data),
    .word_done  (word_done),
    .word_cnt   (word_cnt),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata)
  );

endmodule
